// File: rtl/sm83_irq_ctrl_if.sv
// MMIO bus bundle between the CPU and the IF (0xFF0F) register.
//   master : CPU side, drives address/data/strobes and samples read data
//   slave  : register side, decodes the access and returns read data
//   A        CPU address bus
//   D_IN     CPU write data
//   D_OUT    read data (8'h00 when not selected)
//   D_OE     read-drive enable for D_OUT
//   RD/WR    CPU read/write strobes
//   MMIO_REQ high when A is in 0xFExx/0xFFxx
interface sm83_irq_ctrl_if;
    logic [15:0] A;
    logic [7:0]  D_IN;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic        RD;
    logic        WR;
    logic        MMIO_REQ;

    modport master (
        output A, D_IN, RD, WR, MMIO_REQ,
        input  D_OUT, D_OE
    );

    modport slave (
        input  A, D_IN, RD, WR, MMIO_REQ,
        output D_OUT, D_OE
    );
endinterface

// File: rtl/sm83_irq_ctrl.sv
// Interrupt-flag (IF) controller feeding the SM83 core's interrupt inputs.
// Synchronises asynchronous peripheral request levels, detects rising edges,
// latches them as pending requests, clears them on core acknowledge and
// exposes the pending set as the IF register on the MMIO bus.
//   CLK          system clock, rising edge
//   RESET        asynchronous active-high reset
//   IRQ_SRC      raw request levels (bit0 VBlank .. bit4 joypad), async
//   bus          MMIO slave port (A, D_IN, D_OUT, D_OE, RD, WR, MMIO_REQ)
//   CPU_IRQ_ACK  per-bit clear from the core
//   CPU_IRQ_TRIG registered pending requests to the core
//   WAKE         registered STOP/HALT wake request
module sm83_irq_ctrl #(
    parameter logic [7:0] IF_ADDR     = 8'h0F,
    parameter logic [7:0] IMPL_MASK   = 8'h1F,
    parameter int         SYNC_STAGES = 2,      // legal 1..3
    parameter logic [7:0] WAKE_MASK   = 8'h10
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [7:0]           IRQ_SRC,
    sm83_irq_ctrl_if.slave       bus,
    input  logic [7:0]           CPU_IRQ_ACK,
    output logic [7:0]           CPU_IRQ_TRIG,
    output logic                 WAKE
);

    logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
    // Tracks which synchroniser stages hold a real post-reset sample.
    logic [SYNC_STAGES-1:0]      vld_q, vld_d;
    logic [7:0]                  prev_q, prev_d;
    logic [7:0]                  pend_q, pend_d;
    logic                        wake_q, wake_d;

    logic [7:0] sync_s;
    logic       sync_vld;
    logic [7:0] set;
    logic [7:0] base;
    logic       hit;
    logic       d_oe;

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign sync_vld = vld_q[SYNC_STAGES-1];

    assign hit = bus.MMIO_REQ && (bus.A[15:8] == 8'hFF) && (bus.A[7:0] == IF_ADDR);

    always_comb begin
        sync_d    = '0;
        vld_d     = '0;
        sync_d[0] = IRQ_SRC;
        vld_d[0]  = 1'b1;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
            vld_d[i]  = vld_q[i-1];
        end

        // The chain flushes zeros for SYNC_STAGES cycles after reset. Holding
        // the history at all-ones until a real sample arrives keeps a source
        // that was high across reset release from looking like a new edge.
        prev_d = sync_vld ? sync_s : 8'hFF;
        set    = sync_s & ~prev_q & IMPL_MASK;

        // Write beats ack; a new edge is OR'd in last so it beats both.
        base   = (bus.WR && hit) ? bus.D_IN : (pend_q & ~CPU_IRQ_ACK);
        pend_d = (base | set) & IMPL_MASK;
        wake_d = |(pend_d & WAKE_MASK);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= '0;
            vld_q  <= '0;
            prev_q <= 8'hFF;
            pend_q <= '0;
            wake_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            vld_q  <= vld_d;
            prev_q <= prev_d;
            pend_q <= pend_d;
            wake_q <= wake_d;
        end
    end

    assign CPU_IRQ_TRIG = pend_q;
    assign WAKE         = wake_q;

    // Read path sees the pre-update register, so a same-cycle write or set
    // is not reflected until the next cycle. Reset also silences the drive.
    assign d_oe      = bus.RD && hit && !RESET;
    assign bus.D_OE  = d_oe;
    assign bus.D_OUT = d_oe ? (pend_q | ~IMPL_MASK) : 8'h00;

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
module tb_sm83_irq_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] IRQ_SRC;
    logic [7:0] CPU_IRQ_ACK;
    logic [7:0] CPU_IRQ_TRIG;
    logic       WAKE;

    int n_cmp = 0;
    int n_err = 0;

    sm83_irq_ctrl_if bus ();

    sm83_irq_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .IRQ_SRC      (IRQ_SRC),
        .bus          (bus),
        .CPU_IRQ_ACK  (CPU_IRQ_ACK),
        .CPU_IRQ_TRIG (CPU_IRQ_TRIG),
        .WAKE         (WAKE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  src;
        logic [7:0]  ack;
        logic        wr;
        logic        rd;
        logic        req;
        logic [15:0] a;
        logic [7:0]  din;
        logic        exp_oe;    // before the edge
        logic [7:0]  exp_dout;  // before the edge
        logic [7:0]  exp_trig;  // after the edge
        logic        exp_wake;  // after the edge
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_idle();
        bus.A        = 16'h0000;
        bus.D_IN     = 8'h00;
        bus.RD       = 1'b0;
        bus.WR       = 1'b0;
        bus.MMIO_REQ = 1'b0;
        CPU_IRQ_ACK  = 8'h00;
    endtask

    task automatic do_reset(input logic [7:0] src);
        bus_idle();
        IRQ_SRC = src;
        RESET   = 1'b1;
        repeat (2) tick();
        RESET   = 1'b0;
    endtask

    task automatic write_if(input logic [7:0] v);
        bus.A = 16'hFF0F; bus.D_IN = v; bus.WR = 1'b1; bus.MMIO_REQ = 1'b1;
        tick();
        bus_idle();
    endtask

    initial begin
        // src, ack, wr, rd, req, a, din, exp_oe, exp_dout, exp_trig, exp_wake
        tbl[0]  = '{8'h01, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 8'h00, 0};
        tbl[1]  = '{8'h01, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 8'h00, 0};
        tbl[2]  = '{8'h01, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 8'h01, 0};
        tbl[3]  = '{8'h08, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 8'h01, 0};
        tbl[4]  = '{8'h08, 8'h00, 0, 1, 1, 16'hFF0F, 8'h00, 1, 8'hE1, 8'h01, 0};
        tbl[5]  = '{8'h08, 8'h01, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 8'h08, 0};
        tbl[6]  = '{8'h00, 8'h08, 1, 0, 1, 16'hFF0F, 8'h12, 0, 8'h00, 8'h12, 1};
        tbl[7]  = '{8'h00, 8'h10, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 8'h02, 0};
        tbl[8]  = '{8'h00, 8'h00, 1, 0, 0, 16'hFF0F, 8'h1F, 0, 8'h00, 8'h02, 0};
        tbl[9]  = '{8'h00, 8'h00, 1, 0, 1, 16'hFE0F, 8'h1F, 0, 8'h00, 8'h02, 0};
        tbl[10] = '{8'h00, 8'h00, 0, 1, 1, 16'hFF0E, 8'h00, 0, 8'h00, 8'h02, 0};
        tbl[11] = '{8'h00, 8'h00, 1, 1, 1, 16'hFF0F, 8'hFF, 1, 8'hE2, 8'h1F, 1};
        tbl[12] = '{8'h00, 8'h1F, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 8'h00, 0};
        tbl[13] = '{8'h00, 8'h04, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 8'h00, 0};

        // Reset state
        IRQ_SRC = 8'h00;
        bus_idle();
        RESET = 1'b1;
        #2;
        chk("reset trig", CPU_IRQ_TRIG, 8'h00);
        chk("reset wake", {7'b0, WAKE}, 8'h00);
        chk("reset d_oe", {7'b0, bus.D_OE}, 8'h00);
        chk("reset d_out", bus.D_OUT, 8'h00);
        repeat (2) tick();
        RESET = 1'b0;
        repeat (4) tick();

        // Table-driven stream
        for (int i = 0; i < 14; i++) begin
            IRQ_SRC      = tbl[i].src;
            CPU_IRQ_ACK  = tbl[i].ack;
            bus.WR       = tbl[i].wr;
            bus.RD       = tbl[i].rd;
            bus.MMIO_REQ = tbl[i].req;
            bus.A        = tbl[i].a;
            bus.D_IN     = tbl[i].din;
            #1;
            chk($sformatf("vec%0d d_oe", i), {7'b0, bus.D_OE}, {7'b0, tbl[i].exp_oe});
            chk($sformatf("vec%0d d_out", i), bus.D_OUT, tbl[i].exp_dout);
            tick();
            chk($sformatf("vec%0d trig", i), CPU_IRQ_TRIG, tbl[i].exp_trig);
            chk($sformatf("vec%0d wake", i), {7'b0, WAKE}, {7'b0, tbl[i].exp_wake});
        end
        bus_idle();

        // Edge latency: SYNC_STAGES+1 edges after the source change
        do_reset(8'h00);
        repeat (4) tick();
        IRQ_SRC = 8'h01;
        repeat (2) tick();
        chk("lat early", CPU_IRQ_TRIG, 8'h00);
        tick();
        chk("lat on time", CPU_IRQ_TRIG, 8'h01);
        repeat (3) tick();
        chk("lat held", CPU_IRQ_TRIG, 8'h01);
        IRQ_SRC = 8'h00;
        repeat (3) tick();
        IRQ_SRC = 8'h01;
        repeat (3) tick();
        chk("re-edge pending", CPU_IRQ_TRIG, 8'h01);

        // Source high across reset release gives no request
        do_reset(8'h04);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("held src %0d", i), CPU_IRQ_TRIG, 8'h00);
        end
        IRQ_SRC = 8'h00;
        repeat (3) tick();
        IRQ_SRC = 8'h04;
        repeat (2) tick();
        chk("held src rearm early", CPU_IRQ_TRIG, 8'h00);
        tick();
        chk("held src rearm", CPU_IRQ_TRIG, 8'h04);

        // Ack, and ack colliding with a new edge
        do_reset(8'h00);
        repeat (4) tick();
        write_if(8'h05);
        chk("sw write 05", CPU_IRQ_TRIG, 8'h05);
        CPU_IRQ_ACK = 8'h01;
        tick();
        CPU_IRQ_ACK = 8'h00;
        chk("ack bit0", CPU_IRQ_TRIG, 8'h04);
        IRQ_SRC = 8'h04;
        repeat (2) tick();
        CPU_IRQ_ACK = 8'h04;
        tick();
        CPU_IRQ_ACK = 8'h00;
        chk("ack vs edge", CPU_IRQ_TRIG, 8'h04);
        CPU_IRQ_ACK = 8'h04;
        tick();
        CPU_IRQ_ACK = 8'h00;
        chk("ack bit2", CPU_IRQ_TRIG, 8'h00);

        // Write masking and read decode
        write_if(8'hE3);
        chk("write E3", CPU_IRQ_TRIG, 8'h03);
        bus.A = 16'hFF0F; bus.RD = 1'b1; bus.MMIO_REQ = 1'b1;
        #1;
        chk("read IF oe", {7'b0, bus.D_OE}, 8'h01);
        chk("read IF data", bus.D_OUT, 8'hE3);
        bus.A = 16'hFF0E;
        #1;
        chk("read FF0E oe", {7'b0, bus.D_OE}, 8'h00);
        chk("read FF0E data", bus.D_OUT, 8'h00);
        bus_idle();

        // Joypad wake, clear by write, async reset with everything pending
        do_reset(8'h00);
        repeat (4) tick();
        IRQ_SRC = 8'h10;
        repeat (3) tick();
        chk("joy trig", CPU_IRQ_TRIG, 8'h10);
        chk("joy wake", {7'b0, WAKE}, 8'h01);
        write_if(8'h00);
        chk("wake cleared", {7'b0, WAKE}, 8'h00);
        chk("trig cleared", CPU_IRQ_TRIG, 8'h00);
        write_if(8'h1F);
        chk("all pending", CPU_IRQ_TRIG, 8'h1F);
        chk("all pending wake", {7'b0, WAKE}, 8'h01);
        bus.A = 16'hFF0F; bus.RD = 1'b1; bus.MMIO_REQ = 1'b1;
        #2;
        RESET = 1'b1;
        #1;
        chk("async rst trig", CPU_IRQ_TRIG, 8'h00);
        chk("async rst wake", {7'b0, WAKE}, 8'h00);
        chk("async rst d_oe", {7'b0, bus.D_OE}, 8'h00);
        chk("async rst d_out", bus.D_OUT, 8'h00);
        tick();
        bus_idle();
        RESET = 1'b0;

        // Reset while a request is still in the synchroniser
        IRQ_SRC = 8'h00;
        repeat (4) tick();
        IRQ_SRC = 8'h08;
        tick();
        IRQ_SRC = 8'h00;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        repeat (4) tick();
        chk("sync flight reset", CPU_IRQ_TRIG, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
